// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU MAC sequencing and writeback blocks.
package npu_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int REQ_W  = ACC_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    SETTLE,
    OUTPUT
  } mac_seq_state_e;

  function automatic logic [7:0] sat_int8(input logic signed [REQ_W-1:0] v);
    if (v > 33'sd127) begin
      return 8'h7f;
    end else if (v < -33'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Round-half-up arithmetic right shift of an INT32 accumulator, saturated to INT8.
module requant_sat
  import npu_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [4:0]        shift,
  output logic [DATA_W-1:0] res_q
);

  logic signed [REQ_W-1:0] acc_x;
  logic signed [REQ_W-1:0] rnd;
  logic signed [REQ_W-1:0] t;
  logic signed [REQ_W-1:0] s;

  // One extra bit of headroom so the rounding add cannot overflow.
  always_comb begin
    acc_x = {acc[ACC_W-1], acc};
    rnd   = '0;
    if (shift != 5'd0) begin
      rnd = REQ_W'(1) << (shift - 5'd1);
    end
    t     = acc_x + rnd;
    s     = t >>> shift;
    res_q = sat_int8(s);
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one dot product on an INT8 MAC and hands the INT32 sum plus an
// INT8 requantized copy to the writeback path.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle MAC clear strobe
// STREAM | accepting operand pairs, MAC enabled per handshake
// SETTLE | MAC output final, capture raw and requantized result
// OUTPUT | result offered until res_ready
module mac_seq_ctrl
  import npu_pkg::*;
#(
  parameter int DATA_W = npu_pkg::DATA_W,
  parameter int ACC_W  = npu_pkg::ACC_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [4:0]        cfg_shift,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_weight,
  input  logic [DATA_W-1:0] op_act,
  output logic              mac_enable,
  output logic              mac_clear,
  output logic [DATA_W-1:0] mac_weight,
  output logic [DATA_W-1:0] mac_activation,
  input  logic [ACC_W-1:0]  mac_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_acc,
  output logic [DATA_W-1:0] res_q
);

  mac_seq_state_e    state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [4:0]        shift_q;
  logic [DATA_W-1:0] q_next;
  logic              hs;
  logic              last_hs;

  // op_ready is a registered copy of (state == STREAM), so it gates the datapath.
  assign hs             = op_ready && op_valid;
  assign last_hs        = hs && (cnt == (len_q - LEN_W'(1)));
  assign mac_enable     = hs;
  assign mac_weight     = op_ready ? op_weight : '0;
  assign mac_activation = op_ready ? op_act    : '0;

  requant_sat u_requant_sat (
    .acc   (mac_result),
    .shift (shift_q),
    .res_q (q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      busy      <= 1'b0;
      op_ready  <= 1'b0;
      mac_clear <= 1'b0;
      res_valid <= 1'b0;
      res_acc   <= '0;
      res_q     <= '0;
    end else begin
      mac_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= cfg_len;
            shift_q   <= cfg_shift;
            cnt       <= '0;
            busy      <= 1'b1;
            mac_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (len_q == '0) begin
            state <= SETTLE;
          end else begin
            op_ready <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            cnt <= cnt + LEN_W'(1);
          end
          if (last_hs) begin
            op_ready <= 1'b0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          res_acc   <= mac_result;
          res_q     <= q_next;
          res_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          op_ready  <= 1'b0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC and a result scoreboard.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst, start, op_valid, res_ready;
  logic busy, op_ready, mac_enable, mac_clear, res_valid;
  logic [15:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic signed [7:0]  op_weight, op_act, mac_weight, mac_activation, res_q;
  logic signed [31:0] mac_result, res_acc;

  typedef struct {
    int acc;
    int q;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   en_cnt   = 0;
  int   clr_cnt  = 0;
  int   rdy_cnt  = 0;
  bit   overlap  = 1'b0;
  logic signed [31:0] mac_acc = '0;
  logic signed [7:0]  wv[8];
  logic signed [7:0]  av[8];

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_len        (cfg_len),
    .cfg_shift      (cfg_shift),
    .busy           (busy),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_weight      (op_weight),
    .op_act         (op_act),
    .mac_enable     (mac_enable),
    .mac_clear      (mac_clear),
    .mac_weight     (mac_weight),
    .mac_activation (mac_activation),
    .mac_result     (mac_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_acc        (res_acc),
    .res_q          (res_q)
  );

  // Behavioural MAC: not cleared by rst, so stale contents survive a reset.
  assign mac_result = mac_acc;
  always @(posedge clk) begin
    if (mac_clear) mac_acc <= '0;
    else if (mac_enable) mac_acc <= mac_acc + mac_weight * mac_activation;
    if (mac_enable) en_cnt <= en_cnt + 1;
    if (mac_clear) clr_cnt <= clr_cnt + 1;
    if (op_ready) rdy_cnt <= rdy_cnt + 1;
    if (mac_enable && mac_clear) overlap <= 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0d required=none", res_acc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_acc", res_acc, e.acc);
        chk("sb_q", res_q, e.q);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input int sh);
    start     = 1'b1;
    cfg_len   = len[15:0];
    cfg_shift = sh[4:0];
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 1;
    while (!op_ready && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic send_ops(input int n, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        op_valid = 1'b0;
        tick();
      end
      op_valid  = 1'b1;
      op_weight = wv[i];
      op_act    = av[i];
      t = 0;
      while (!op_ready && t < 64) begin
        tick();
        t++;
      end
      tick();
    end
    op_valid = 1'b0;
  endtask

  task automatic load_t1();
    wv[0] = 8'sd1;  av[0] = 8'sd2;
    wv[1] = 8'sd3;  av[1] = 8'sd4;
    wv[2] = -8'sd5; av[2] = 8'sd6;
    wv[3] = 8'sd7;  av[3] = -8'sd8;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, e0, c0, r0;
    rst = 1'b1; start = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
    cfg_len = '0; cfg_shift = '0; op_weight = '0; op_act = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_mac_enable", mac_enable, 0);
    chk("rst_mac_clear", mac_clear, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_acc", res_acc, 0);
    chk("rst_res_q", res_q, 0);
    rst = 1'b0;
    tick();

    // 1: basic dot product, no shift
    load_t1();
    e0 = en_cnt; c0 = clr_cnt; r0 = rdy_cnt;
    exp_q.push_back('{acc: -72, q: -72});
    do_start(4, 0);
    chk("t1_busy", busy, 1);
    chk("t1_clear", mac_clear, 1);
    chk("t1_ready_early", op_ready, 0);
    wait_ready(lat);
    chk("t1_start_lat", lat, 2);
    chk("t1_clear_drop", mac_clear, 0);
    send_ops(4, 1'b0);
    wait_res(lat);
    chk("t1_res_lat", lat, 2);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_enables", en_cnt - e0, 4);
    chk("t1_clears", clr_cnt - c0, 1);
    chk("t1_ready_cyc", rdy_cnt - r0, 4);

    // 2: saturation
    for (int i = 0; i < 3; i++) begin
      wv[i] = 8'sd127;
      av[i] = 8'sd127;
    end
    exp_q.push_back('{acc: 48387, q: 127});
    do_start(3, 8);
    wait_ready(lat);
    send_ops(3, 1'b0);
    wait_res(lat);
    chk("t2_res_lat", lat, 2);
    tick();

    // 3: shift with rounding, held result, ignored start
    load_t1();
    exp_q.push_back('{acc: -72, q: -4});
    res_ready = 1'b0;
    do_start(4, 4);
    wait_ready(lat);
    send_ops(4, 1'b0);
    wait_res(lat);
    chk("t3_res_lat", lat, 2);
    c0 = clr_cnt;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        start = 1'b1;
        cfg_len = 16'd1;
      end
      tick();
      start = 1'b0;
      chk("t3_hold_valid", res_valid, 1);
      chk("t3_hold_acc", res_acc, -72);
      chk("t3_hold_q", res_q, -4);
      chk("t3_hold_busy", busy, 1);
    end
    chk("t3_no_restart", clr_cnt - c0, 0);
    res_ready = 1'b1;
    tick();
    chk("t3_idle", busy, 0);
    tick();
    chk("t3_still_idle", busy, 0);
    chk("t3_no_clear", mac_clear, 0);

    // 4: zero length
    e0 = en_cnt; c0 = clr_cnt;
    exp_q.push_back('{acc: 0, q: 0});
    do_start(0, 0);
    chk("t4_clear", mac_clear, 1);
    wait_res(lat);
    chk("t4_res_lat", lat, 3);
    tick();
    chk("t4_enables", en_cnt - e0, 0);
    chk("t4_clears", clr_cnt - c0, 1);

    // 5: reset mid-stream, then a fresh one-element run
    load_t1();
    do_start(4, 0);
    wait_ready(lat);
    send_ops(2, 1'b0);
    rst = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_op_ready", op_ready, 0);
    chk("t5_res_valid", res_valid, 0);
    rst = 1'b0;
    tick();
    wv[0] = 8'sd2; av[0] = 8'sd3;
    exp_q.push_back('{acc: 6, q: 6});
    do_start(1, 0);
    wait_ready(lat);
    send_ops(1, 1'b0);
    wait_res(lat);
    chk("t5_res_lat", lat, 2);
    tick();

    // 6: op_valid gaps
    load_t1();
    e0 = en_cnt; r0 = rdy_cnt;
    exp_q.push_back('{acc: -72, q: -72});
    do_start(4, 0);
    wait_ready(lat);
    send_ops(4, 1'b1);
    wait_res(lat);
    chk("t6_res_lat", lat, 2);
    tick();
    chk("t6_enables", en_cnt - e0, 4);
    chk("t6_ready_cyc", rdy_cnt - r0, 8);

    tick();
    chk("sb_drained", exp_q.size(), 0);
    chk("clear_enable_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
